// File: rtl/line_frame_gen.sv
// Raster timing generator: walks pixel coordinates under a valid/ready handshake
// and emits one-cycle frameStart / newLine / endFrame strobes, all registered.
module line_frame_gen #(
  parameter int unsigned PIX_PER_LINE    = 32,
  parameter int unsigned LINES_PER_FRAME = 24,
  parameter int unsigned H_BLANK         = 4,
  parameter int unsigned V_BLANK         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gen_enb,
  input  logic       pix_ready,
  output logic       pix_valid,
  output logic [5:0] pix_x,
  output logic [4:0] pix_y,
  output logic       frameStart,
  output logic       newLine,
  output logic       endFrame
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HBLANK = 2'd2;
  localparam logic [1:0] S_VBLANK = 2'd3;

  localparam logic [5:0] X_LAST = 6'(PIX_PER_LINE - 1);
  localparam logic [4:0] Y_LAST = 5'(LINES_PER_FRAME - 1);
  localparam logic [3:0] H_LAST = 4'(H_BLANK - 1);
  localparam logic [3:0] V_LAST = 4'(V_BLANK - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [3:0] blk_q, blk_d;

  logic       pix_valid_q, pix_valid_d;
  logic [5:0] pix_x_q, pix_x_d;
  logic [4:0] pix_y_q, pix_y_d;
  logic       frame_start_q, frame_start_d;
  logic       new_line_q, new_line_d;
  logic       end_frame_q, end_frame_d;

  logic       accept;

  assign accept = pix_valid_q && pix_ready;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    blk_d         = blk_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    new_line_d    = 1'b0;
    end_frame_d   = 1'b0;

    if (!gen_enb) begin
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      blk_d   = '0;
      pix_x_d = '0;
      pix_y_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d       = S_ACTIVE;
          x_d           = '0;
          y_d           = '0;
          blk_d         = '0;
          frame_start_d = 1'b1;
        end
        S_ACTIVE: begin
          if (accept) begin
            if (x_q == X_LAST) begin
              state_d    = S_HBLANK;
              x_d        = '0;
              blk_d      = '0;
              new_line_d = 1'b1;
            end else begin
              x_d = x_q + 6'd1;
            end
          end
        end
        S_HBLANK: begin
          if (blk_q == H_LAST) begin
            blk_d = '0;
            if (y_q == Y_LAST) begin
              state_d     = S_VBLANK;
              y_d         = '0;
              end_frame_d = 1'b1;
            end else begin
              state_d = S_ACTIVE;
              y_d     = y_q + 5'd1;
            end
          end else begin
            blk_d = blk_q + 4'd1;
          end
        end
        default: begin
          if (blk_q == V_LAST) begin
            blk_d         = '0;
            state_d       = S_ACTIVE;
            x_d           = '0;
            y_d           = '0;
            frame_start_d = 1'b1;
          end else begin
            blk_d = blk_q + 4'd1;
          end
        end
      endcase
    end

    // Visible coordinates track the counters only while active; otherwise they hold.
    if (state_d == S_ACTIVE) begin
      pix_x_d = x_d;
      pix_y_d = y_d;
    end
    pix_valid_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      blk_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      new_line_q    <= 1'b0;
      end_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      blk_q         <= blk_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      new_line_q    <= new_line_d;
      end_frame_q   <= end_frame_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frameStart = frame_start_q;
  assign newLine    = new_line_q;
  assign endFrame   = end_frame_q;

endmodule

// File: tb/tb_line_frame_gen.sv
// Directed bench for line_frame_gen: default-size instance plus a small-parameter instance.
module tb_line_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, gen_enb, pix_ready;
  logic       pix_valid, frameStart, newLine, endFrame;
  logic [5:0] pix_x;
  logic [4:0] pix_y;

  logic       s_enb, s_ready;
  logic       s_valid, s_fs, s_nl, s_ef;
  logic [5:0] s_x;
  logic [4:0] s_y;

  int n_cmp = 0;
  int n_err = 0;

  line_frame_gen dut (
    .clk(clk), .rst(rst), .gen_enb(gen_enb), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frameStart(frameStart), .newLine(newLine), .endFrame(endFrame)
  );

  line_frame_gen #(
    .PIX_PER_LINE(4), .LINES_PER_FRAME(2), .H_BLANK(2), .V_BLANK(3)
  ) dut_s (
    .clk(clk), .rst(rst), .gen_enb(s_enb), .pix_ready(s_ready),
    .pix_valid(s_valid), .pix_x(s_x), .pix_y(s_y),
    .frameStart(s_fs), .newLine(s_nl), .endFrame(s_ef)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({pix_valid, pix_x, pix_y, frameStart, newLine, endFrame} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0",
               {pix_valid, pix_x, pix_y, frameStart, newLine, endFrame});
    end
    rst = 1'b0;
    gen_enb = 1'b1;
    tick();
    n_cmp++;
    if ({frameStart, pix_valid, pix_x, pix_y} !== {1'b1, 1'b1, 6'd0, 5'd0}) begin
      n_err++;
      $display("FAIL first_frame_start: got fs=%b v=%b x=%0d y=%0d expected fs=1 v=1 x=0 y=0",
               frameStart, pix_valid, pix_x, pix_y);
    end
    repeat (118) tick();
    n_cmp++;
    if ({pix_valid, pix_x, pix_y} !== {1'b1, 6'd10, 5'd3}) begin
      n_err++;
      $display("FAIL reach_10_3: got v=%b x=%0d y=%0d expected v=1 x=10 y=3",
               pix_valid, pix_x, pix_y);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pix_valid, pix_x, pix_y, frameStart, newLine, endFrame} !== 15'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0",
               {pix_valid, pix_x, pix_y, frameStart, newLine, endFrame});
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({frameStart, pix_valid, pix_x, pix_y, newLine, endFrame} !== {1'b1, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL restart_after_reset: got fs=%b v=%b x=%0d y=%0d nl=%b ef=%b expected fs=1 v=1 x=0 y=0 nl=0 ef=0",
               frameStart, pix_valid, pix_x, pix_y, newLine, endFrame);
    end
  endtask

  task automatic test_small_params();
    logic [14:0] exp_tab [16];
    logic [14:0] got;
    // {valid, frameStart, newLine, endFrame, x, y}
    exp_tab[0]  = {4'b1100, 6'd0, 5'd0};
    exp_tab[1]  = {4'b1000, 6'd1, 5'd0};
    exp_tab[2]  = {4'b1000, 6'd2, 5'd0};
    exp_tab[3]  = {4'b1000, 6'd3, 5'd0};
    exp_tab[4]  = {4'b0010, 6'd3, 5'd0};
    exp_tab[5]  = {4'b0000, 6'd3, 5'd0};
    exp_tab[6]  = {4'b1000, 6'd0, 5'd1};
    exp_tab[7]  = {4'b1000, 6'd1, 5'd1};
    exp_tab[8]  = {4'b1000, 6'd2, 5'd1};
    exp_tab[9]  = {4'b1000, 6'd3, 5'd1};
    exp_tab[10] = {4'b0010, 6'd3, 5'd1};
    exp_tab[11] = {4'b0000, 6'd3, 5'd1};
    exp_tab[12] = {4'b0001, 6'd3, 5'd1};
    exp_tab[13] = {4'b0000, 6'd3, 5'd1};
    exp_tab[14] = {4'b0000, 6'd3, 5'd1};
    exp_tab[15] = {4'b1100, 6'd0, 5'd0};
    s_ready = 1'b1;
    s_enb = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      got = {s_valid, s_fs, s_nl, s_ef, s_x, s_y};
      n_cmp++;
      if (got !== exp_tab[k]) begin
        n_err++;
        $display("FAIL small_seq[%0d]: got v/fs/nl/ef=%b x=%0d y=%0d expected v/fs/nl/ef=%b x=%0d y=%0d",
                 k, got[14:11], got[10:5], got[4:0], exp_tab[k][14:11], exp_tab[k][10:5], exp_tab[k][4:0]);
      end
    end
    s_enb = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit found;
    gen_enb = 1'b0;
    pix_ready = 1'b1;
    tick();
    gen_enb = 1'b1;
    tick();
    cyc = 0;
    repeat (7) begin tick(); cyc++; end
    n_cmp++;
    if ({pix_valid, pix_x} !== {1'b1, 6'd7}) begin
      n_err++;
      $display("FAIL bp_reach_x7: got v=%b x=%0d expected v=1 x=7", pix_valid, pix_x);
    end
    pix_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      cyc++;
      n_cmp++;
      if ({pix_valid, pix_x, newLine} !== {1'b1, 6'd7, 1'b0}) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got v=%b x=%0d nl=%b expected v=1 x=7 nl=0",
                 s, pix_valid, pix_x, newLine);
      end
    end
    pix_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc++;
      if (newLine) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found || cyc != 37) begin
      n_err++;
      $display("FAIL bp_newline_time: got found=%0d cycles=%0d expected found=1 cycles=37", found, cyc);
    end
    n_cmp++;
    if ({pix_valid, pix_x, pix_y} !== {1'b0, 6'd31, 5'd0}) begin
      n_err++;
      $display("FAIL bp_hold_after_line: got v=%b x=%0d y=%0d expected v=0 x=31 y=0",
               pix_valid, pix_x, pix_y);
    end
  endtask

  task automatic test_full_frame();
    int cyc, nl_cnt, ef_cnt, last_nl, ef_at, multi, period;
    gen_enb = 1'b0;
    pix_ready = 1'b1;
    tick();
    gen_enb = 1'b1;
    tick();
    n_cmp++;
    if (frameStart !== 1'b1) begin
      n_err++;
      $display("FAIL full_fs_start: got %b expected 1", frameStart);
    end
    cyc = 0; nl_cnt = 0; ef_cnt = 0; last_nl = -1; ef_at = -1; multi = 0; period = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      cyc++;
      if (newLine) begin nl_cnt++; last_nl = cyc; end
      if (endFrame) begin ef_cnt++; ef_at = cyc; end
      if ((int'(frameStart) + int'(newLine) + int'(endFrame)) > 1) multi++;
      if (frameStart) begin period = cyc; break; end
    end
    n_cmp++;
    if (period != 866) begin
      n_err++;
      $display("FAIL full_period: got %0d expected 866", period);
    end
    n_cmp++;
    if (nl_cnt != 24) begin
      n_err++;
      $display("FAIL full_newline_count: got %0d expected 24", nl_cnt);
    end
    n_cmp++;
    if (ef_cnt != 1) begin
      n_err++;
      $display("FAIL full_endframe_count: got %0d expected 1", ef_cnt);
    end
    n_cmp++;
    if (ef_at - last_nl != 4) begin
      n_err++;
      $display("FAIL full_endframe_gap: got %0d expected 4", ef_at - last_nl);
    end
    n_cmp++;
    if (multi != 0) begin
      n_err++;
      $display("FAIL full_strobe_exclusive: got %0d overlapping cycles expected 0", multi);
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    int strobes;
    gen_enb = 1'b0;
    pix_ready = 1'b1;
    tick();
    gen_enb = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (newLine && pix_y == 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL drop_find_line5: got found=0 expected found=1");
    end
    gen_enb = 1'b0;
    tick();
    n_cmp++;
    if ({pix_valid, pix_x, pix_y, frameStart, newLine, endFrame} !== 15'd0) begin
      n_err++;
      $display("FAIL drop_idle_outputs: got %h expected 0",
               {pix_valid, pix_x, pix_y, frameStart, newLine, endFrame});
    end
    strobes = 0;
    repeat (5) begin
      tick();
      if (pix_valid || frameStart || newLine || endFrame) strobes++;
    end
    n_cmp++;
    if (strobes != 0) begin
      n_err++;
      $display("FAIL drop_quiet: got %0d active cycles expected 0", strobes);
    end
    gen_enb = 1'b1;
    tick();
    n_cmp++;
    if ({frameStart, pix_valid, pix_x, pix_y} !== {1'b1, 1'b1, 6'd0, 5'd0}) begin
      n_err++;
      $display("FAIL drop_restart: got fs=%b v=%b x=%0d y=%0d expected fs=1 v=1 x=0 y=0",
               frameStart, pix_valid, pix_x, pix_y);
    end
  endtask

  task automatic test_back_to_back();
    int fs_cnt, nl_cnt, ef_cnt, wraps, viol;
    logic [4:0] last_y;
    bit seen_ef;
    gen_enb = 1'b0;
    pix_ready = 1'b1;
    tick();
    gen_enb = 1'b1;
    tick();
    fs_cnt = frameStart ? 1 : 0;
    nl_cnt = 0; ef_cnt = 0; wraps = 0; viol = 0;
    last_y = pix_y;
    seen_ef = 1'b0;
    for (int c = 1; c < 3 * 866; c++) begin
      tick();
      if (frameStart) fs_cnt++;
      if (newLine) nl_cnt++;
      if (endFrame) begin ef_cnt++; seen_ef = 1'b1; end
      if (pix_valid) begin
        if (pix_y != last_y) begin
          if (pix_y == 5'd0) begin
            wraps++;
            if (!seen_ef || last_y != 5'd23) viol++;
          end else if (pix_y != last_y + 5'd1) begin
            viol++;
          end
        end
        last_y = pix_y;
        seen_ef = 1'b0;
      end
    end
    n_cmp++;
    if (fs_cnt != 3) begin
      n_err++;
      $display("FAIL b2b_framestart_count: got %0d expected 3", fs_cnt);
    end
    n_cmp++;
    if (nl_cnt != 72) begin
      n_err++;
      $display("FAIL b2b_newline_count: got %0d expected 72", nl_cnt);
    end
    n_cmp++;
    if (ef_cnt != 3) begin
      n_err++;
      $display("FAIL b2b_endframe_count: got %0d expected 3", ef_cnt);
    end
    n_cmp++;
    if (wraps != 2 || viol != 0) begin
      n_err++;
      $display("FAIL b2b_y_wrap: got wraps=%0d violations=%0d expected wraps=2 violations=0", wraps, viol);
    end
    tick();
    n_cmp++;
    if ({frameStart, pix_x, pix_y} !== {1'b1, 6'd0, 5'd0}) begin
      n_err++;
      $display("FAIL b2b_fourth_frame: got fs=%b x=%0d y=%0d expected fs=1 x=0 y=0",
               frameStart, pix_x, pix_y);
    end
    gen_enb = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    gen_enb = 1'b0;
    pix_ready = 1'b1;
    s_enb = 1'b0;
    s_ready = 1'b1;
    test_reset();
    test_small_params();
    test_backpressure();
    test_full_frame();
    test_enable_drop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_frame_gen.md
Name: line_frame_gen

Overview:
- Timing generator on the transmit side of the line/frame protocol.
- Produces raster pixel coordinates with a valid/ready handshake, plus one-cycle newLine and endFrame strobes.
- Downstream line counters consume these strobes: one newLine per active line, 24 lines per frame by default.
- Sits between the pattern controller (gen_enb) and the pattern/pixel datapath (pix_ready).

Parameters:
- PIX_PER_LINE, 32: active pixels per line; legal range 1..64.
- LINES_PER_FRAME, 24: active lines per frame; legal range 1..32.
- H_BLANK, 4: idle cycles after each line; legal range 1..15.
- V_BLANK, 2: idle cycles after the last line's H_BLANK; legal range 1..15.

Ports:
- clk  in  1  master clock
- rst  in  1  asynchronous active-high reset
- gen_enb  in  1  active-high run enable
- pix_ready  in  1  downstream accepts the current pixel
- pix_valid  out  1  pix_x/pix_y hold a valid active pixel
- pix_x  out  6  pixel column, 0..PIX_PER_LINE-1
- pix_y  out  5  line index, 0..LINES_PER_FRAME-1
- frameStart  out  1  one-cycle pulse on the first ACTIVE cycle of a frame
- newLine  out  1  one-cycle pulse after each line's last pixel is accepted
- endFrame  out  1  one-cycle pulse on the first VBLANK cycle

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; all outputs 0; x, y and blank counters 0. The same holds when reset is applied mid-frame; no strobe is emitted on reset release.
- All outputs are registered.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- gen_enb=0 in any state: next cycle state=IDLE, counters cleared, all outputs 0. A partial frame is abandoned with no newLine/endFrame.
- IDLE:
  - With gen_enb=1, go to ACTIVE next cycle with x=0, y=0.
  - frameStart=1 for that first ACTIVE cycle.
- ACTIVE:
  - pix_valid=1; pix_x=x, pix_y=y.
  - A pixel is accepted when pix_valid&&pix_ready.
  - On accept with x<PIX_PER_LINE-1: x increments.
  - With pix_ready=0: coordinates hold, indefinitely if needed.
  - Accept at x=PIX_PER_LINE-1: go to HBLANK next cycle with newLine=1 for exactly that cycle; x clears to 0.
- HBLANK:
  - pix_valid=0; lasts exactly H_BLANK cycles.
  - Then, if y<LINES_PER_FRAME-1: y increments and state goes to ACTIVE.
  - Otherwise: go to VBLANK with endFrame=1 on its first cycle; y clears to 0.
- VBLANK:
  - pix_valid=0; lasts exactly V_BLANK cycles.
  - Then go to ACTIVE (new frame, frameStart=1) if gen_enb=1, else IDLE.
- newLine count per frame = LINES_PER_FRAME. endFrame follows the final newLine by exactly H_BLANK cycles.
- Frame period with pix_ready held 1 = LINES_PER_FRAME*(PIX_PER_LINE+H_BLANK)+V_BLANK cycles, frameStart to frameStart (866 at defaults).
- Strobes are mutually exclusive: newLine, endFrame and frameStart never assert in the same cycle.
- pix_x/pix_y hold their last values outside ACTIVE; consumers qualify with pix_valid.

Test Plan:
- Reset mid-ACTIVE: assert rst at pix_x=10, pix_y=3 -> same cycle all outputs 0, state IDLE; after release with gen_enb=1 -> frameStart, pix_x=0, pix_y=0.
- Small params (P=4, L=2, H=2, V=3), pix_ready=1, gen_enb=1:
  - Sequence: frameStart, pixels (0,0)..(3,0), newLine, 2 blank cycles, (0,1)..(3,1), newLine, 2 blank cycles, endFrame, 3 blank cycles, next frameStart.
  - Required: 15 cycles between frameStart pulses.
- Backpressure: defaults, drop pix_ready for 5 cycles at pix_x=7 -> pix_x stays 7, pix_valid=1, no newLine; resume -> line completes normally, 5 cycles later than unstalled.
- Full default frame: count strobes -> exactly 24 newLine, 1 endFrame 4 cycles after the 24th newLine, frame period 866.
- Enable drop: deassert gen_enb during HBLANK of line 5 -> IDLE next cycle, no further strobes; re-enable -> frame restarts at (0,0) with frameStart.
- Back-to-back frames: gen_enb held 1 for 3 frames -> 3 frameStart, 72 newLine, 3 endFrame; pix_y wraps 23->0 only via VBLANK.
